// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST response analyzer.
package bist_pkg;

    // Analyzer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } ra_state_t;

    // CRC-16/CCITT tap mask, the usual MISR feedback choice.
    localparam logic [15:0] BIST_DEFAULT_POLY = 16'h1021;

    // Width of the externally visible pattern counter.
    localparam int BIST_CNT_W = 16;

    // Clamp an internal count that is one bit wider than the port to the port width.
    // Only a full 2^16-pattern run ever reaches the top bit.
    function automatic logic [BIST_CNT_W-1:0] cnt_to_port(input logic [BIST_CNT_W:0] cnt);
        if (cnt[BIST_CNT_W]) begin
            return {BIST_CNT_W{1'b1}};
        end
        return cnt[BIST_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: one shift/XOR step per enabled cycle,
// loadable with a seed, cleared by reset.
module bist_misr #(
    parameter int                RESP_W = 1,
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]  SEED   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] data_ext;
    logic [SIG_W-1:0] feedback;

    // Next signature: seed on load, otherwise shift left, fold in taps and response.
    always_comb begin
        data_ext               = '0;
        data_ext[RESP_W-1:0]   = data;
        feedback               = sig_q[SIG_W-1] ? POLY : '0;
        sig_d                  = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ feedback ^ data_ext;
        end
    end

    // Signature register; reset clears it to zero rather than to the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_resp_analyzer.sv
// BIST output-response analyzer: compacts PAT_COUNT CUT responses into a MISR,
// then compares the signature with a golden value and reports pass/fail.
// Optional feature: define BIST_RESP_ANALYZER_XMASK_EN to add a resp_mask input
// whose set bits are forced to 0 before compaction.
module bist_resp_analyzer
    import bist_pkg::*;
#(
    parameter int               RESP_W    = 1,
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] POLY      = SIG_W'(BIST_DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED      = '0,
    parameter int               PAT_COUNT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  resp_valid,
    input  logic [RESP_W-1:0]     resp,
`ifdef BIST_RESP_ANALYZER_XMASK_EN
    input  logic [RESP_W-1:0]     resp_mask,
`endif
    input  logic [SIG_W-1:0]      golden,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [SIG_W-1:0]      signature,
    output logic [BIST_CNT_W-1:0] pat_cnt
);

    // One extra counter bit so a 2^16-pattern run can count to PAT_COUNT without wrapping.
    localparam int                CNT_X_W  = BIST_CNT_W + 1;
    localparam logic [CNT_X_W-1:0] CNT_LAST = CNT_X_W'(PAT_COUNT - 1);

    ra_state_t          state_q, state_d;
    logic [CNT_X_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               misr_load;
    logic               misr_en;
    logic [RESP_W-1:0]  resp_eff;
    logic [SIG_W-1:0]   sig;

`ifdef BIST_RESP_ANALYZER_XMASK_EN
    assign resp_eff = resp & ~resp_mask;
`else
    assign resp_eff = resp;
`endif

    bist_misr #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .en   (misr_en),
        .data (resp_eff),
        .sig  (sig)
    );

    // FSM next state, counter, pass flag and MISR controls.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (resp_valid) begin
                    misr_en = 1'b1;
                    cnt_d   = cnt_q + CNT_X_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                // The final signature is already registered here, so one compare cycle suffices.
                pass_d  = (sig == golden);
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    // Control registers; status outputs are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig;
    assign pat_cnt   = cnt_to_port(cnt_q);

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// Testbench for bist_resp_analyzer: scoreboard of expected end-of-run results
// checked by per-DUT monitors on the rising edge of done, plus inline checks.
`timescale 1ns/1ps
module tb_bist_resp_analyzer;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    exp_t q_big[$];
    exp_t q_small[$];

    // Default-parameter DUT
    logic        b_start = 0, b_valid = 0;
    logic [0:0]  b_resp = '0, b_mask = '0;
    logic [15:0] b_golden = '0;
    logic        b_busy, b_done, b_pass;
    logic [15:0] b_sig, b_cnt;

    // Small DUT: SIG_W=4, POLY=3, PAT_COUNT=2
    logic        s_start = 0, s_valid = 0;
    logic [0:0]  s_resp = '0, s_mask = '0;
    logic [3:0]  s_golden = '0;
    logic        s_busy, s_done, s_pass;
    logic [3:0]  s_sig;
    logic [15:0] s_cnt;

    bist_resp_analyzer dut_big (
        .clk(clk), .rst(rst), .start(b_start), .resp_valid(b_valid), .resp(b_resp),
`ifdef BIST_RESP_ANALYZER_XMASK_EN
        .resp_mask(b_mask),
`endif
        .golden(b_golden), .busy(b_busy), .done(b_done), .pass(b_pass),
        .signature(b_sig), .pat_cnt(b_cnt)
    );

    bist_resp_analyzer #(.RESP_W(1), .SIG_W(4), .POLY(4'h3), .SEED(4'h0), .PAT_COUNT(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .resp_valid(s_valid), .resp(s_resp),
`ifdef BIST_RESP_ANALYZER_XMASK_EN
        .resp_mask(s_mask),
`endif
        .golden(s_golden), .busy(s_busy), .done(s_done), .pass(s_pass),
        .signature(s_sig), .pat_cnt(s_cnt)
    );

`ifdef BIST_RESP_ANALYZER_XMASK_EN
    logic        x_start = 0, x_valid = 0;
    logic [1:0]  x_resp = '0, x_mask = 2'b10;
    logic [3:0]  x_golden = 4'h3;
    logic        x_busy, x_done, x_pass;
    logic [3:0]  x_sig;
    logic [15:0] x_cnt;

    bist_resp_analyzer #(.RESP_W(2), .SIG_W(4), .POLY(4'h3), .SEED(4'h0), .PAT_COUNT(2)) dut_x (
        .clk(clk), .rst(rst), .start(x_start), .resp_valid(x_valid), .resp(x_resp),
        .resp_mask(x_mask),
        .golden(x_golden), .busy(x_busy), .done(x_done), .pass(x_pass),
        .signature(x_sig), .pat_cnt(x_cnt)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Deterministic single-bit response stream for the long runs.
    function automatic logic rbit(input int i);
        return 1'(((i >> 0) ^ (i >> 2) ^ (i >> 5)) & 1);
    endfunction

    // Reference MISR (SIG_W=16, POLY=16'h1021, SEED=0) over the first n responses.
    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] s;
        s = 16'h0;
        for (int i = 0; i < n; i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'h0, rbit(i)};
        end
        return s;
    endfunction

    // Monitor: every rising edge of done on the default DUT retires one expected result.
    logic b_done_prev = 1'b0;
    always @(negedge clk) begin
        if (b_done && !b_done_prev) begin
            if (q_big.size() == 0) begin
                chk("big_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_big.pop_front();
                chk("big_sig", b_sig, e.sig);
                chk("big_pass", b_pass, e.pass);
                chk("big_cnt", b_cnt, e.cnt);
            end
        end
        b_done_prev = b_done;
    end

    // Monitor for the small DUT.
    logic s_done_prev = 1'b0;
    always @(negedge clk) begin
        if (s_done && !s_done_prev) begin
            if (q_small.size() == 0) begin
                chk("small_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_small.pop_front();
                chk("small_sig", s_sig, e.sig);
                chk("small_pass", s_pass, e.pass);
                chk("small_cnt", s_cnt, e.cnt);
            end
        end
        s_done_prev = s_done;
    end

    task automatic run_big(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            b_valid = 1'b1;
            b_resp  = rbit(i);
            tick();
            b_valid = 1'b0;
            if (gaps) repeat (i % 4) tick();
        end
        b_valid = 1'b0;
    endtask

    task automatic wait_big_done();
        for (int k = 0; k < 8 && !b_done; k++) tick();
        chk("big_done_timeout", b_done, 1'b1);
    endtask

    task automatic start_big();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("big_busy_after_start", b_busy, 1'b1);
    endtask

    initial begin
        logic [15:0] ref_sig;
        // Reset together with start: reset must win.
        rst = 1'b1; b_start = 1'b1; s_start = 1'b1;
        tick();
        tick();
        b_start = 1'b0; s_start = 1'b0;
        chk("rst_busy", b_busy, 1'b0);
        chk("rst_done", b_done, 1'b0);
        chk("rst_pass", b_pass, 1'b0);
        chk("rst_sig", b_sig, 16'h0);
        chk("rst_cnt", b_cnt, 16'h0);
        chk("rst_small_sig", s_sig, 4'h0);
        rst = 1'b0;
        tick();

        // Small run, golden matches: 0 -> 1 -> 3
        s_golden = 4'h3;
        q_small.push_back('{sig: 16'h3, pass: 1'b1, cnt: 16'd2});
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("small_busy_rise", s_busy, 1'b1);
        s_valid = 1'b1; s_resp = 1'b1;
        tick();
        chk("small_sig_step1", s_sig, 4'h1);
        tick();
        s_valid = 1'b0;
        chk("small_sig_step2", s_sig, 4'h3);
        chk("small_done_not_yet", s_done, 1'b0);
        tick();
        chk("small_done_two_edges", s_done, 1'b1);
        chk("small_busy_in_done", s_busy, 1'b0);

        // resp_valid pulsed in DONE must be ignored.
        s_valid = 1'b1; s_resp = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("small_done_valid_sig", s_sig, 4'h3);
        chk("small_done_valid_cnt", s_cnt, 16'd2);
        chk("small_done_hold", s_done, 1'b1);

        // Small run, golden mismatches; start pulsed mid-run is ignored.
        s_golden = 4'h2;
        q_small.push_back('{sig: 16'h3, pass: 1'b0, cnt: 16'd2});
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("small_restart_sig", s_sig, 4'h0);
        s_valid = 1'b1; s_resp = 1'b1;
        tick();
        s_valid = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("small_midrun_start_sig", s_sig, 4'h1);
        chk("small_midrun_start_cnt", s_cnt, 16'd1);
        s_valid = 1'b1; s_resp = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        chk("small_fail_done", s_done, 1'b1);

        // Default DUT: gap-free run with matching golden.
        ref_sig  = model_sig(256);
        b_golden = ref_sig;
        q_big.push_back('{sig: ref_sig, pass: 1'b1, cnt: 16'd256});
        start_big();
        run_big(256, 1'b0);
        wait_big_done();

        // Same stream with idle gaps; mismatching golden.
        b_golden = ref_sig ^ 16'h0001;
        q_big.push_back('{sig: ref_sig, pass: 1'b0, cnt: 16'd256});
        start_big();
        run_big(256, 1'b1);
        wait_big_done();

        // Reset after 100 accepted responses.
        start_big();
        run_big(100, 1'b0);
        chk("big_cnt_100", b_cnt, 16'd100);
        chk("big_sig_100", b_sig, model_sig(100));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", b_busy, 1'b0);
        chk("midrst_sig", b_sig, 16'h0);
        chk("midrst_cnt", b_cnt, 16'h0);
        chk("midrst_done", b_done, 1'b0);

        // A later run after reset completes normally.
        b_golden = ref_sig;
        q_big.push_back('{sig: ref_sig, pass: 1'b1, cnt: 16'd256});
        start_big();
        run_big(256, 1'b1);
        wait_big_done();

`ifdef BIST_RESP_ANALYZER_XMASK_EN
        // Masked upper bit: 2'b11 and 2'b01 compact identically to 4'h3.
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            x_start = 1'b1;
            tick();
            x_start = 1'b0;
            x_valid = 1'b1;
            x_resp  = (pass_i == 0) ? 2'b11 : 2'b01;
            tick();
            tick();
            x_valid = 1'b0;
            tick();
            chk("xmask_done", x_done, 1'b1);
            chk("xmask_sig", x_sig, 4'h3);
            chk("xmask_pass", x_pass, 1'b1);
        end
`endif

        repeat (3) tick();
        chk("big_queue_drained", q_big.size(), 0);
        chk("small_queue_drained", q_small.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
